// File: rtl/dtw_dispatch.sv
// rtl/dtw_dispatch.sv - round-robin query dispatcher and in-order result collector for DTW cores
module dtw_dispatch #(
    parameter int NUM_CORES = 4,
    parameter int DW        = 32,
    parameter int RES_W     = 24,
    parameter int LEN_W     = 16
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    soft_rst,
    input  logic                    rs,
    input  logic [LEN_W-1:0]        query_len,
    input  logic                    src_fifo_empty,
    input  logic [DW-1:0]           src_fifo_data,
    output logic                    src_fifo_rden,
    input  logic [NUM_CORES-1:0]    core_idle,
    output logic [NUM_CORES-1:0]    core_wvalid,
    output logic [DW-1:0]           core_wdata,
    input  logic [NUM_CORES-1:0]    core_wready,
    input  logic [NUM_CORES-1:0]    core_res_valid,
    input  logic [NUM_CORES*DW-1:0] core_res_data,
    output logic [NUM_CORES-1:0]    core_res_ack,
    input  logic                    sink_fifo_full,
    output logic                    sink_fifo_wren,
    output logic [DW-1:0]           sink_fifo_data,
    output logic                    busy,
    output logic                    err_len,
    output logic [31:0]             n_done
);

    localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      rr, sel, pick, head;
    logic [ID_W:0]        idx_sum;
    logic [NUM_CORES-1:0] inflight, eligible;
    logic [LEN_W-1:0]     len_q, cnt;
    logic [ID_W-1:0]      idq [NUM_CORES];
    logic [ID_W-1:0]      wr_ptr, rd_ptr;
    logic [ID_W:0]        q_cnt;
    logic                 found, start, disp, xfer, last, collect;
    logic [DW-1:0]        res_word;
    logic                 unused_res;

    assign eligible = core_idle & ~inflight;

    // First eligible core at or after the round-robin pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        idx_sum = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx_sum = {1'b0, rr} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(NUM_CORES))
                idx_sum = idx_sum - (ID_W+1)'(NUM_CORES);
            if (!found && eligible[idx_sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx_sum[ID_W-1:0];
            end
        end
    end

    assign start   = (state == S_IDLE) && rs && !src_fifo_empty && found;
    assign disp    = start && (query_len != '0);
    assign xfer    = (state == S_STREAM) && !src_fifo_empty && core_wready[sel];
    assign last    = xfer && (cnt == len_q - LEN_W'(1));
    assign head    = idq[rd_ptr];
    assign collect = (q_cnt != '0) && core_res_valid[head] && !sink_fifo_full;
    assign busy    = (state != S_IDLE) || (inflight != '0);

    always_comb begin
        state_nxt     = state;
        core_wvalid   = '0;
        core_wdata    = '0;
        src_fifo_rden = 1'b0;
        case (state)
            S_IDLE: begin
                if (disp)
                    state_nxt = S_STREAM;
            end
            S_STREAM: begin
                core_wvalid[sel] = !src_fifo_empty;
                core_wdata       = src_fifo_data;
                src_fifo_rden    = xfer;
                if (last)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        res_word = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (head == ID_W'(i))
                res_word = core_res_data[i*DW +: DW];
    end

    assign unused_res     = ^res_word[DW-1:RES_W];
    assign sink_fifo_wren = collect;
    assign core_res_ack   = collect ? (NUM_CORES'(1) << head) : '0;
    assign sink_fifo_data = collect ? {8'(head), res_word[RES_W-1:0]} : '0;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            state <= S_IDLE;
        else if (soft_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr       <= '0;
            sel      <= '0;
            len_q    <= '0;
            cnt      <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            err_len  <= 1'b0;
            n_done   <= '0;
        end else if (soft_rst) begin
            rr       <= '0;
            sel      <= '0;
            len_q    <= '0;
            cnt      <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            err_len  <= 1'b0;
            n_done   <= '0;
        end else begin
            if (start && (query_len == '0))
                err_len <= 1'b1;
            if (disp) begin
                sel    <= pick;
                len_q  <= query_len;
                cnt    <= '0;
                rr     <= (pick == ID_W'(NUM_CORES-1)) ? '0 : pick + ID_W'(1);
                wr_ptr <= (wr_ptr == ID_W'(NUM_CORES-1)) ? '0 : wr_ptr + ID_W'(1);
            end else if (xfer) begin
                cnt <= cnt + LEN_W'(1);
            end
            if (collect) begin
                rd_ptr <= (rd_ptr == ID_W'(NUM_CORES-1)) ? '0 : rd_ptr + ID_W'(1);
                n_done <= n_done + 32'd1;
            end
            // A core cannot be dispatched and collected in the same cycle, so set and clear never collide.
            inflight <= (inflight | (disp ? (NUM_CORES'(1) << pick) : '0))
                        & ~(collect ? (NUM_CORES'(1) << head) : '0);
            case ({disp, collect})
                2'b10:   q_cnt <= q_cnt + (ID_W+1)'(1);
                2'b01:   q_cnt <= q_cnt - (ID_W+1)'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (disp)
            idq[wr_ptr] <= pick;
    end

endmodule

// File: tb/tb_dtw_dispatch.sv
// tb/tb_dtw_dispatch.sv - scoreboard bench for dtw_dispatch
module tb_dtw_dispatch;
    localparam int NC    = 4;
    localparam int DW    = 32;
    localparam int RES_W = 24;
    localparam int LEN_W = 16;

    logic              clk = 1'b0;
    logic              aresetn, soft_rst, rs;
    logic [LEN_W-1:0]  query_len;
    logic              src_fifo_empty;
    logic [DW-1:0]     src_fifo_data;
    logic              src_fifo_rden;
    logic [NC-1:0]     core_idle, core_wvalid, core_wready, core_res_valid, core_res_ack;
    logic [DW-1:0]     core_wdata;
    logic [NC*DW-1:0]  core_res_data;
    logic              sink_fifo_full, sink_fifo_wren;
    logic [DW-1:0]     sink_fifo_data;
    logic              busy, err_len;
    logic [31:0]       n_done;

    dtw_dispatch #(.NUM_CORES(NC), .DW(DW), .RES_W(RES_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .aresetn(aresetn), .soft_rst(soft_rst), .rs(rs), .query_len(query_len),
        .src_fifo_empty(src_fifo_empty), .src_fifo_data(src_fifo_data), .src_fifo_rden(src_fifo_rden),
        .core_idle(core_idle), .core_wvalid(core_wvalid), .core_wdata(core_wdata),
        .core_wready(core_wready), .core_res_valid(core_res_valid), .core_res_data(core_res_data),
        .core_res_ack(core_res_ack), .sink_fifo_full(sink_fifo_full), .sink_fifo_wren(sink_fifo_wren),
        .sink_fifo_data(sink_fifo_data), .busy(busy), .err_len(err_len), .n_done(n_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rden_cnt = 0;
    int first_x = -1;
    int last_x = 0;

    logic [DW-1:0] src_mem [256];
    logic [7:0]    src_wr = 8'd0;
    logic [7:0]    src_rd = 8'd0;
    assign src_fifo_empty = (src_wr == src_rd);
    assign src_fifo_data  = src_fifo_empty ? '0 : src_mem[src_rd];

    logic [7:0] res_gen  [NC];
    logic [7:0] res_ackg [NC];
    always_comb begin
        core_res_valid = '0;
        for (int i = 0; i < NC; i++)
            core_res_valid[i] = (res_gen[i] != res_ackg[i]);
    end

    logic [39:0]   exp_w [$];
    logic [DW-1:0] exp_s [$];
    logic [39:0]   e_w;
    logic [DW-1:0] e_s;
    logic          pop_pend = 1'b0;
    logic [NC-1:0] ack_pend = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_query(input int core, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            src_mem[src_wr] = base + DW'(k);
            src_wr = src_wr + 8'd1;
            exp_w.push_back({8'(core), base + DW'(k)});
        end
    endtask

    task automatic expect_sink(input int core, input logic [DW-1:0] d);
        exp_s.push_back({8'(core), d[RES_W-1:0]});
    endtask

    task automatic post_result(input int core, input logic [DW-1:0] d);
        core_res_data[core*DW +: DW] = d;
        res_gen[core] = res_gen[core] + 8'd1;
    endtask

    task automatic wait_words(input string name, input int max);
        int n = 0;
        while (exp_w.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_w.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: %0d words still outstanding, required 0", name, exp_w.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_sink(input string name, input int max);
        int n = 0;
        while (exp_s.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_s.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: %0d results still outstanding, required 0", name, exp_s.size());
        end
        @(negedge clk);
    endtask

    // Monitor: sample at negedge, pop scoreboards on every DUT transfer.
    always @(negedge clk) begin
        cyc++;
        pop_pend = src_fifo_rden;
        ack_pend = core_res_ack;
        if (src_fifo_rden) rden_cnt++;
        for (int i = 0; i < NC; i++) begin
            if (core_wvalid[i] && core_wready[i]) begin
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                if (exp_w.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL word_unexpected: core %0d data %0h, required no transfer", i, core_wdata);
                end else begin
                    e_w = exp_w.pop_front();
                    check("word", {24'h0, 8'(i), core_wdata}, {24'h0, e_w});
                end
            end
        end
        if (sink_fifo_wren) begin
            if (exp_s.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL sink_unexpected: data %0h, required no write", sink_fifo_data);
            end else begin
                e_s = exp_s.pop_front();
                check("sink", {32'h0, sink_fifo_data}, {32'h0, e_s});
            end
        end
    end

    // Source FIFO and core result models consume the pops seen at the previous negedge.
    always @(posedge clk) begin
        #1;
        if (pop_pend && (src_rd != src_wr)) src_rd = src_rd + 8'd1;
        for (int i = 0; i < NC; i++)
            if (ack_pend[i]) res_ackg[i] = res_ackg[i] + 8'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < NC; i++) begin
            res_gen[i]  = 8'd0;
            res_ackg[i] = 8'd0;
        end
        aresetn = 1'b0; soft_rst = 1'b0; rs = 1'b0; query_len = '0;
        sink_fifo_full = 1'b0; core_idle = '0; core_wready = '1; core_res_data = '0;
        repeat (3) @(negedge clk);
        check("rst_rden",  {63'h0, src_fifo_rden}, 64'h0);
        check("rst_wvalid", {60'h0, core_wvalid}, 64'h0);
        check("rst_wren",  {63'h0, sink_fifo_wren}, 64'h0);
        check("rst_busy",  {63'h0, busy}, 64'h0);
        check("rst_err",   {63'h0, err_len}, 64'h0);
        check("rst_ndone", {32'h0, n_done}, 64'h0);
        @(posedge clk); #1 aresetn = 1'b1;
        @(negedge clk);

        // Four 3-word queries round-robin to cores 0..3, back to back.
        base = rden_cnt;
        first_x = -1;
        for (int q = 0; q < 4; q++) send_query(q, 32'h100 + 32'(q*3), 3);
        query_len = 16'd3; core_idle = 4'hF; rs = 1'b1;
        wait_words("t1_words", 100);
        check("t1_rden", 64'(rden_cnt - base), 64'd12);
        check("t1_span", 64'(last_x - first_x), 64'd14);
        check("t1_busy", {63'h0, busy}, 64'h1);

        // Results arrive 2,0,1,3 but leave in dispatch order 0,1,2,3.
        for (int c = 0; c < 4; c++) expect_sink(c, 32'hF1A5_5A00 + 32'(c));
        post_result(2, 32'hF1A5_5A02);
        repeat (5) @(negedge clk);
        check("t2_hold", {32'h0, n_done}, 64'd0);
        post_result(0, 32'hF1A5_5A00);
        repeat (2) @(negedge clk);
        post_result(1, 32'hF1A5_5A01);
        repeat (2) @(negedge clk);
        post_result(3, 32'hF1A5_5A03);
        wait_sink("t2_sink", 50);
        check("t2_ndone", {32'h0, n_done}, 64'd4);
        check("t2_busy", {63'h0, busy}, 64'h0);

        // Core 1 not idle: cores 0,2,3 served, fourth query waits for core 0.
        core_idle = 4'b1101;
        send_query(0, 32'h200, 3);
        send_query(2, 32'h203, 3);
        send_query(3, 32'h206, 3);
        send_query(0, 32'h209, 3);
        repeat (30) @(negedge clk);
        check("t3_src_level", {56'h0, src_wr - src_rd}, 64'd3);
        check("t3_pending", 64'(exp_w.size()), 64'd3);
        expect_sink(0, 32'h0012_3400);
        post_result(0, 32'h0012_3400);
        wait_words("t3_words", 60);
        expect_sink(2, 32'h7777_0002);
        expect_sink(3, 32'h8888_0003);
        expect_sink(0, 32'h9999_0010);
        post_result(3, 32'h8888_0003);
        post_result(2, 32'h7777_0002);
        repeat (2) @(negedge clk);
        post_result(0, 32'h9999_0010);
        wait_sink("t3_sink", 50);
        check("t3_ndone", {32'h0, n_done}, 64'd8);
        check("t3_busy", {63'h0, busy}, 64'h0);

        // Sink full for 10 cycles holds the result; it goes out on the first free cycle.
        core_idle = 4'hF;
        sink_fifo_full = 1'b1;
        send_query(1, 32'h300, 3);
        wait_words("t4_words", 40);
        expect_sink(1, 32'hABCD_EF01);
        post_result(1, 32'hABCD_EF01);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (sink_fifo_wren || (core_res_ack != '0)) n++;
        end
        check("t4_full_hold", 64'(n), 64'd0);
        @(posedge clk); #1 sink_fifo_full = 1'b0;
        @(negedge clk);
        check("t4_first_push", {63'h0, sink_fifo_wren}, 64'h1);
        wait_sink("t4_sink", 20);
        check("t4_ndone", {32'h0, n_done}, 64'd9);

        // Zero length query: sticky error, nothing popped, cleared by soft reset.
        base = rden_cnt;
        query_len = '0;
        src_mem[src_wr] = 32'h400;
        src_wr = src_wr + 8'd1;
        repeat (4) @(negedge clk);
        check("t5_err", {63'h0, err_len}, 64'h1);
        check("t5_rden", 64'(rden_cnt - base), 64'd0);
        check("t5_busy", {63'h0, busy}, 64'h0);
        rs = 1'b0;
        @(posedge clk); #1 soft_rst = 1'b1;
        @(posedge clk); #1 soft_rst = 1'b0;
        @(negedge clk);
        check("t5_err_clr", {63'h0, err_len}, 64'h0);
        check("t5_ndone_clr", {32'h0, n_done}, 64'd0);
        src_wr = src_rd;

        // Async reset while streaming word 1 of 3.
        query_len = 16'd3; rs = 1'b1;
        for (int k = 0; k < 3; k++) begin
            src_mem[src_wr] = 32'h500 + 32'(k);
            src_wr = src_wr + 8'd1;
        end
        exp_w.push_back({8'd0, 32'h500});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_wvalid[0] && n < 20);
        check("t6_word0_seen", {63'h0, core_wvalid[0]}, 64'h1);
        @(posedge clk); #2 aresetn = 1'b0;
        #1;
        check("t6_wvalid", {60'h0, core_wvalid}, 64'h0);
        check("t6_rden", {63'h0, src_fifo_rden}, 64'h0);
        check("t6_busy", {63'h0, busy}, 64'h0);
        check("t6_wdata", {32'h0, core_wdata}, 64'h0);
        @(negedge clk);
        src_wr = src_rd;
        @(posedge clk); #1 aresetn = 1'b1;
        @(negedge clk);
        send_query(0, 32'h600, 3);
        wait_words("t6_words", 40);
        check("t6_busy_after", {63'h0, busy}, 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
